// File: rtl/avalon_adapter_pkg.sv
// Shared types and helpers for the Avalon read-modify-write memory adapter.
package avalon_adapter_pkg;

    // Adapter control states: idle command handling, waiting for the old word,
    // and writing back the merged word.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RMW_WAIT  = 2'd1,
        RMW_WRITE = 2'd2
    } rmw_state_t;

    // Widest byte-enable vector the mask helper can describe.
    localparam int MAX_BYTES = 64;

    // Byte-enable pattern that covers every byte of a DATAWIDTH-bit word.
    function automatic logic [MAX_BYTES-1:0] full_enable_mask(input int datawidth);
        logic [MAX_BYTES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < datawidth / 8) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/avalon_read_tag_pipe.sv
// Fixed-depth tag pipeline that travels alongside block-RAM reads so the
// returning data can be qualified (host vs internal) and optionally replaced
// by a forwarded word.
module avalon_read_tag_pipe #(
    parameter int LATENCY   = 1,
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_internal,
    input  logic                 in_forward,
    input  logic [DATAWIDTH-1:0] in_forward_data,
    output logic                 out_valid,
    output logic                 out_internal,
    output logic                 out_forward,
    output logic [DATAWIDTH-1:0] out_forward_data
);

    localparam int TAG_W = DATAWIDTH + 3;

    logic [TAG_W-1:0] slot_reg [LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_slot
            // Each slot takes the previous slot's tag; slot 0 takes the new read.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_reg[gi] <= '0;
                end else if (gi == 0) begin
                    slot_reg[gi] <= {in_valid, in_internal, in_forward, in_forward_data};
                end else begin
                    slot_reg[gi] <= slot_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign {out_valid, out_internal, out_forward, out_forward_data} = slot_reg[LATENCY-1];

endmodule

// File: rtl/avalon_rmw_memory_adapter.sv
// Avalon-MM slave in front of a block RAM. Full-word writes go straight
// through; partial writes become a read-modify-write. Reads that hit the word
// written in the previous cycle are served from a forwarding register.
module avalon_rmw_memory_adapter
    import avalon_adapter_pkg::*;
#(
    parameter int BUSWIDTH     = 32,
    parameter int DATAWIDTH    = 32,
    parameter int DATADEPTH    = 1024,
    parameter int LATENCY      = 1,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESSWIDTH-1:0] address,
    input  logic [BUSWIDTH/8-1:0]   byteenable,
    input  logic [BUSWIDTH-1:0]     data_in,
    output logic                    waitrequest,
    output logic                    read_valid,
    output logic [BUSWIDTH-1:0]     data_out,
    output logic                    mem_read_en,
    output logic                    mem_write_en,
    output logic [ADDRESSWIDTH-1:0] mem_address,
    output logic [DATAWIDTH-1:0]    mem_data_in,
    input  logic [DATAWIDTH-1:0]    mem_data_out
);

    localparam int NBYTES = DATAWIDTH / 8;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [MAX_BYTES-1:0] FULL_MASK_W = full_enable_mask(DATAWIDTH);
    localparam logic [NBYTES-1:0]    FULL_MASK   = FULL_MASK_W[NBYTES-1:0];
    localparam logic [CNT_W-1:0]     WAIT_LAST   = CNT_W'(LATENCY - 1);

    rmw_state_t state_reg, state_next;

    logic [NBYTES-1:0]       be_eff;
    logic [ADDRESSWIDTH-1:0] cap_addr_reg;
    logic [DATAWIDTH-1:0]    cap_data_reg;
    logic [NBYTES-1:0]       cap_be_reg;
    logic [DATAWIDTH-1:0]    old_reg;
    logic [DATAWIDTH-1:0]    merged;
    logic [CNT_W-1:0]        wait_cnt_reg;
    logic                    cap_en;

    logic                    lw_valid_reg;
    logic [ADDRESSWIDTH-1:0] lw_addr_reg;
    logic [DATAWIDTH-1:0]    lw_data_reg;

    logic                    push_valid, push_internal, push_forward;
    logic                    tag_valid, tag_internal, tag_forward;
    logic [DATAWIDTH-1:0]    tag_forward_data;
    logic [DATAWIDTH-1:0]    rd_word;

    assign be_eff = byteenable[NBYTES-1:0];

    // Enabled bytes come from the captured write data, the rest from the old word.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = cap_be_reg[gi] ? cap_data_reg[gi*8 +: 8] : old_reg[gi*8 +: 8];
        end
    endgenerate

    // Next-state and strobe decode; reset silences every strobe.
    always_comb begin
        state_next    = state_reg;
        waitrequest   = 1'b0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_address   = address;
        mem_data_in   = '0;
        push_valid    = 1'b0;
        push_internal = 1'b0;
        cap_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (write) begin
                    if (be_eff == FULL_MASK) begin
                        mem_write_en = 1'b1;
                        mem_data_in  = data_in[DATAWIDTH-1:0];
                    end else if (be_eff != '0) begin
                        waitrequest   = 1'b1;
                        mem_read_en   = 1'b1;
                        push_valid    = 1'b1;
                        push_internal = 1'b1;
                        cap_en        = 1'b1;
                        state_next    = RMW_WAIT;
                    end
                end else if (read) begin
                    mem_read_en = 1'b1;
                    push_valid  = 1'b1;
                end
            end
            RMW_WAIT: begin
                waitrequest = 1'b1;
                mem_address = cap_addr_reg;
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = RMW_WRITE;
                end
            end
            RMW_WRITE: begin
                mem_write_en = 1'b1;
                mem_address  = cap_addr_reg;
                mem_data_in  = merged;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            waitrequest  = 1'b0;
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            push_valid   = 1'b0;
            cap_en       = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Capture the partial write and count the old-word read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_addr_reg <= '0;
            cap_data_reg <= '0;
            cap_be_reg   <= '0;
            wait_cnt_reg <= '0;
        end else if (cap_en) begin
            cap_addr_reg <= address;
            cap_data_reg <= data_in[DATAWIDTH-1:0];
            cap_be_reg   <= be_eff;
            wait_cnt_reg <= '0;
        end else if (state_reg == RMW_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // Latch the old word as the internal read returns during RMW_WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_reg <= '0;
        end else if (state_reg == RMW_WAIT && tag_valid && tag_internal) begin
            old_reg <= rd_word;
        end
    end

    // Remember the last memory write for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lw_valid_reg <= 1'b0;
            lw_addr_reg  <= '0;
            lw_data_reg  <= '0;
        end else begin
            lw_valid_reg <= mem_write_en;
            lw_addr_reg  <= mem_address;
            lw_data_reg  <= mem_data_in;
        end
    end

    // A read right behind a write to the same word must not see the stale RAM output.
    assign push_forward = lw_valid_reg && (lw_addr_reg == address);

    avalon_read_tag_pipe #(
        .LATENCY   (LATENCY),
        .DATAWIDTH (DATAWIDTH)
    ) u_tag_pipe (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (push_valid),
        .in_internal      (push_internal),
        .in_forward       (push_forward),
        .in_forward_data  (lw_data_reg),
        .out_valid        (tag_valid),
        .out_internal     (tag_internal),
        .out_forward      (tag_forward),
        .out_forward_data (tag_forward_data)
    );

    assign rd_word    = tag_forward ? tag_forward_data : mem_data_out;
    assign read_valid = tag_valid && !tag_internal;
    assign data_out   = read_valid ? BUSWIDTH'(rd_word) : '0;

endmodule

// File: tb/tb_avalon_rmw_memory_adapter.sv
// Directed bench for the RMW adapter with a LATENCY=2 block-RAM model whose
// writes land one cycle late, so a read right behind a write sees stale data
// unless the adapter forwards.
module tb_avalon_rmw_memory_adapter;

    localparam int BW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          read, write;
    logic [AW-1:0] address;
    logic [BW/8-1:0] byteenable;
    logic [BW-1:0] data_in;
    logic          waitrequest, read_valid;
    logic [BW-1:0] data_out;
    logic          mem_read_en, mem_write_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    avalon_rmw_memory_adapter #(
        .BUSWIDTH (BW), .DATAWIDTH (DW), .DATADEPTH (DEPTH), .LATENCY (LAT)
    ) dut (
        .clk (clk), .reset (reset), .read (read), .write (write),
        .address (address), .byteenable (byteenable), .data_in (data_in),
        .waitrequest (waitrequest), .read_valid (read_valid), .data_out (data_out),
        .mem_read_en (mem_read_en), .mem_write_en (mem_write_en),
        .mem_address (mem_address), .mem_data_in (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Block-RAM model: two-stage read pipe, write committed one cycle late.
    logic [DW-1:0] ram [0:DEPTH-1];
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_a = '0;
    logic [DW-1:0] pend_d = '0;
    logic [DW-1:0] rd1 = '0, rd2 = '0;

    always @(posedge clk) begin
        if (pend_v) ram[pend_a] <= pend_d;
        pend_v <= mem_write_en;
        pend_a <= mem_address;
        pend_d <= mem_data_in;
        if (mem_read_en) rd1 <= ram[mem_address];
        rd2 <= rd1;
    end
    assign mem_data_out = rd2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        read = 1'b0;
        write = 1'b0;
        repeat (n) tick();
    endtask

    // Host read, then check the returned word LAT cycles later.
    task automatic read_word(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        read = 1'b1; write = 1'b0; address = a;
        #1;
        tick();
        read = 1'b0;
        tick();
        #1;
        check({tag, "_rv"}, 64'(read_valid), 64'd1);
        check({tag, "_data"}, 64'(data_out), 64'(exp));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'h1000_0000 + i;
        ram[3] = 32'h3333_3333;
        ram[5] = 32'h5555_5555;
        ram[7] = 32'h1122_3344;

        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait", 64'(waitrequest), 64'd0);
        check("rst_rv", 64'(read_valid), 64'd0);
        check("rst_dout", 64'(data_out), 64'd0);
        check("rst_rden", 64'(mem_read_en), 64'd0);
        check("rst_wren", 64'(mem_write_en), 64'd0);
        reset = 1'b0;
        tick();

        // Back-to-back reads of 0,1,2.
        read = 1'b1; address = 10'd0; #1;
        check("b2b_c0_wait", 64'(waitrequest), 64'd0);
        check("b2b_c0_rden", 64'(mem_read_en), 64'd1);
        check("b2b_c0_rv", 64'(read_valid), 64'd0);
        tick();
        address = 10'd1; #1;
        check("b2b_c1_wait", 64'(waitrequest), 64'd0);
        check("b2b_c1_rv", 64'(read_valid), 64'd0);
        tick();
        address = 10'd2; #1;
        check("b2b_c2_wait", 64'(waitrequest), 64'd0);
        check("b2b_c2_data", 64'(data_out), 64'h1000_0000);
        tick();
        read = 1'b0; #1;
        check("b2b_c3_data", 64'(data_out), 64'h1000_0001);
        tick();
        check("b2b_c4_data", 64'(data_out), 64'h1000_0002);
        tick();
        check("b2b_c5_rv", 64'(read_valid), 64'd0);
        check("b2b_c5_dout", 64'(data_out), 64'd0);
        idle(2);

        // Full write then immediate read: forwarded word.
        write = 1'b1; byteenable = 4'hF; address = 10'd5; data_in = 32'hDEAD_BEEF; #1;
        check("fw_wait", 64'(waitrequest), 64'd0);
        check("fw_wren", 64'(mem_write_en), 64'd1);
        check("fw_wdata", 64'(mem_data_in), 64'hDEAD_BEEF);
        tick();
        read_word(10'd5, 32'hDEAD_BEEF, "fwd");
        idle(3);
        read_word(10'd5, 32'hDEAD_BEEF, "late");
        idle(3);

        // Partial write 0xAABBCCDD, be 0101 onto 0x11223344.
        write = 1'b1; byteenable = 4'b0101; address = 10'd7; data_in = 32'hAABB_CCDD; #1;
        check("rmw_c0_wait", 64'(waitrequest), 64'd1);
        check("rmw_c0_rden", 64'(mem_read_en), 64'd1);
        check("rmw_c0_wren", 64'(mem_write_en), 64'd0);
        tick();
        check("rmw_c1_wait", 64'(waitrequest), 64'd1);
        tick();
        check("rmw_c2_wait", 64'(waitrequest), 64'd1);
        check("rmw_c2_rv", 64'(read_valid), 64'd0);
        tick();
        check("rmw_c3_wait", 64'(waitrequest), 64'd0);
        check("rmw_c3_wren", 64'(mem_write_en), 64'd1);
        check("rmw_c3_addr", 64'(mem_address), 64'd7);
        check("rmw_c3_wdata", 64'(mem_data_in), 64'h11BB_33DD);
        tick();
        write = 1'b0; #1;
        check("rmw_c4_wren", 64'(mem_write_en), 64'd0);
        check("rmw_c4_rv", 64'(read_valid), 64'd0);
        idle(3);
        read_word(10'd7, 32'h11BB_33DD, "rmw_mem");
        idle(2);

        // Write with no effective enables.
        write = 1'b1; byteenable = 4'b0000; address = 10'd9; data_in = 32'hFFFF_FFFF; #1;
        check("be0_wait", 64'(waitrequest), 64'd0);
        check("be0_wren", 64'(mem_write_en), 64'd0);
        check("be0_rden", 64'(mem_read_en), 64'd0);
        tick();
        write = 1'b0; #1;
        check("be0_c1_wren", 64'(mem_write_en), 64'd0);
        idle(2);
        read_word(10'd9, 32'h1000_0009, "be0_mem");
        idle(2);

        // Reset during RMW_WAIT with a host read in flight.
        read = 1'b1; address = 10'd0; #1;
        tick();
        read = 1'b0; write = 1'b1; byteenable = 4'b0001; address = 10'd11; data_in = 32'h0000_00AA; #1;
        check("rst_rmw_wait_hi", 64'(waitrequest), 64'd1);
        tick();
        reset = 1'b1; write = 1'b0; #1;
        check("rst_rmw_rv", 64'(read_valid), 64'd0);
        check("rst_rmw_wait", 64'(waitrequest), 64'd0);
        check("rst_rmw_wren0", 64'(mem_write_en), 64'd0);
        tick();
        check("rst_rmw_wren1", 64'(mem_write_en), 64'd0);
        reset = 1'b0; #1;
        tick();
        check("rst_rmw_wren2", 64'(mem_write_en), 64'd0);
        check("rst_rmw_wait2", 64'(waitrequest), 64'd0);
        tick();
        check("rst_rmw_wren3", 64'(mem_write_en), 64'd0);
        check("rst_rmw_rv3", 64'(read_valid), 64'd0);
        read_word(10'd11, 32'h1000_000B, "rst_mem");
        idle(2);

        // Read and write together: write wins.
        read = 1'b1; write = 1'b1; byteenable = 4'hF; address = 10'd3; data_in = 32'hCAFE_F00D; #1;
        check("rw_wren", 64'(mem_write_en), 64'd1);
        check("rw_rden", 64'(mem_read_en), 64'd0);
        check("rw_wait", 64'(waitrequest), 64'd0);
        tick();
        read = 1'b0; write = 1'b0; #1;
        check("rw_c1_rv", 64'(read_valid), 64'd0);
        tick();
        check("rw_c2_rv", 64'(read_valid), 64'd0);
        tick();
        check("rw_c3_rv", 64'(read_valid), 64'd0);
        idle(2);
        read_word(10'd3, 32'hCAFE_F00D, "rw_mem");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/avalon_rmw_memory_adapter.md
AVALON_RMW_MEMORY_ADAPTER -- requirements
Module: avalon_rmw_memory_adapter

Interface
REQ-001 Parameter BUSWIDTH, default 32: Avalon data bus width in bits, a multiple of 8.
REQ-002 Parameter DATAWIDTH, default 32: block-RAM word width in bits, a multiple of 8 and no greater than BUSWIDTH.
REQ-003 Parameter DATADEPTH, default 1024: block-RAM word count.
REQ-004 Parameter LATENCY, default 1: block-RAM read latency in cycles, at least 1.
REQ-005 Parameter ADDRESSWIDTH, default $clog2(DATADEPTH): word address width.
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 read  in  1  Avalon read command.
REQ-009 write  in  1  Avalon write command.
REQ-010 address  in  ADDRESSWIDTH  word address.
REQ-011 byteenable  in  BUSWIDTH/8  per-byte write enables.
REQ-012 data_in  in  BUSWIDTH  write data.
REQ-013 waitrequest  out  1  command stall; the host holds its command while this is high.
REQ-014 read_valid  out  1  data_out is valid this cycle.
REQ-015 data_out  out  BUSWIDTH  read data, zero-extended above DATAWIDTH.
REQ-016 mem_read_en, mem_write_en  out  1 each  block-RAM strobes.
REQ-017 mem_address  out  ADDRESSWIDTH  block-RAM address.
REQ-018 mem_data_in  out  DATAWIDTH  block-RAM write data.
REQ-019 mem_data_out  in  DATAWIDTH  block-RAM read data, valid LATENCY cycles after mem_read_en.

Function
REQ-020 A command is accepted in any cycle where (read or write) is high and waitrequest is low.
REQ-021 Effective enables are byteenable[DATAWIDTH/8-1:0]; higher enable bits and higher data bits are ignored.
REQ-022 The FSM has three states: IDLE, RMW_WAIT and RMW_WRITE.
REQ-023 IDLE with a read: waitrequest stays low, mem_read_en pulses, and read_valid asserts exactly LATENCY cycles later; back-to-back reads sustain one read per cycle.
REQ-024 IDLE with a full write (all effective enables set): waitrequest stays low and a single-cycle mem write is issued.
REQ-025 IDLE with a write whose effective enables are all zero: the write is accepted and no memory access occurs.
REQ-026 IDLE with a partial write: waitrequest goes high combinationally, an internal mem read is issued, address/data/enables are captured, and the FSM moves to RMW_WAIT.
REQ-027 RMW_WAIT lasts LATENCY cycles with waitrequest high, then the FSM moves to RMW_WRITE.
REQ-028 RMW_WRITE: mem write of the merged word (enabled bytes from the captured data, other bytes from the returned old word); waitrequest is low, so the held write is accepted; next state is IDLE.
REQ-029 The internal RMW read never asserts read_valid.
REQ-030 Host reads already in flight when an RMW starts still return on schedule.
REQ-031 read and write high together: the write is serviced and the read is ignored; the read is not accepted.
REQ-032 Forwarding: a last-write register holds the address and word of the most recent mem write, valid for the following cycle only.
REQ-033 A read issued in that following cycle to the same address (host or internal RMW read) returns the forwarded word, not mem_data_out.
REQ-034 Reads issued two or more cycles after a write use mem_data_out.
REQ-035 data_out is zero whenever read_valid is low.

Reset
REQ-036 Reset forces the FSM to IDLE and sets waitrequest, read_valid, data_out, mem_read_en and mem_write_en to 0.
REQ-037 Reset clears the read pipeline and the last-write register.
REQ-038 Reads in flight at reset never produce read_valid.
REQ-039 An RMW interrupted by reset issues no mem write.

Structure
REQ-040 Package avalon_adapter_pkg holds the state enum and a function computing the full-enable mask from DATAWIDTH.
REQ-041 Sub-module avalon_read_tag_pipe is a LATENCY-deep shift register carrying {valid, internal, forward, forward_data} per slot, cleared by reset.

Verification
REQ-042 LATENCY=2; reads to addresses 0, 1, 2 on consecutive cycles -> read_valid high on cycles 2, 3, 4 with the preloaded words, waitrequest never high.
REQ-043 Full write 0xDEADBEEF to address 5, then a read of address 5 the next cycle -> data_out 0xDEADBEEF, not the stale word.
REQ-044 Address 7 holds 0x11223344; write 0xAABBCCDD with byteenable 4'b0101, LATENCY=2 -> waitrequest high for 3 cycles, word becomes 0x11BB33DD, no read_valid from the internal read.
REQ-045 Write with byteenable 0 -> accepted in one cycle, mem_write_en never asserted, memory unchanged.
REQ-046 Reset asserted during RMW_WAIT -> no mem write, FSM in IDLE, waitrequest 0, and the memory word unchanged after reset releases.
REQ-047 read and write high together on address 3 -> write performed, no read_valid follows.
